// File: rtl/pipeline_hazard_ctrl.sv
// Hazard scheduler for the 5-stage core: EX operand forwarding, load-use stall and taken-branch flush.
// Perf counters stall_cnt/flush_cnt are built only when HAZARD_PERF_CNT_EN is defined; otherwise they read 0.
module pipeline_hazard_ctrl #(
  parameter int         LOAD_USE_STALLS = 1,
  parameter logic [4:0] ZERO_REG        = 5'd31
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rn,
  input  logic [4:0]  id_rm,
  input  logic        id_uses_rn,
  input  logic        id_uses_rm,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_is_load,
  input  logic [4:0]  ex_rn,
  input  logic [4:0]  ex_rm,
  input  logic        ex_br_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALLS - 1);

  state_t     state_r, state_nxt_s;
  logic [1:0] cnt_r, cnt_nxt_s;
  logic       ex_valid_r, ex_rw_r, ex_ld_r;
  logic       mem_valid_r, mem_rw_r, wb_valid_r, wb_rw_r;
  logic [4:0] ex_rd_r, mem_rd_r, wb_rd_r;
  logic       luh_s, idex_load_s, flush_evt_s;
  logic       pc_write_s, ifid_write_s, ifid_flush_s, idex_bubble_s;
  logic [1:0] fwd_a_s, fwd_b_s;

  function automatic logic fwd_hit(input logic valid, input logic rw,
                                   input logic [4:0] rd, input logic [4:0] src);
    return valid & rw & (rd == src) & (src != ZERO_REG);
  endfunction

  assign idex_load_s = id_valid & ~idex_bubble_s;

  // Destination shadow of the instructions in EX, MEM and WB
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_r  <= 1'b0;
      ex_rw_r     <= 1'b0;
      ex_ld_r     <= 1'b0;
      ex_rd_r     <= 5'd0;
      mem_valid_r <= 1'b0;
      mem_rw_r    <= 1'b0;
      mem_rd_r    <= 5'd0;
      wb_valid_r  <= 1'b0;
      wb_rw_r     <= 1'b0;
      wb_rd_r     <= 5'd0;
    end else begin
      ex_valid_r  <= idex_load_s;
      ex_rw_r     <= idex_load_s & id_reg_write;
      ex_ld_r     <= idex_load_s & id_is_load;
      ex_rd_r     <= id_rd;
      mem_valid_r <= ex_valid_r;
      mem_rw_r    <= ex_rw_r;
      mem_rd_r    <= ex_rd_r;
      wb_valid_r  <= mem_valid_r;
      wb_rw_r     <= mem_rw_r;
      wb_rd_r     <= mem_rd_r;
    end
  end

  // Operand forwarding select; the younger MEM result wins over WB
  always_comb begin
    fwd_a_s = 2'b00;
    fwd_b_s = 2'b00;
    if (fwd_hit(mem_valid_r, mem_rw_r, mem_rd_r, ex_rn)) begin
      fwd_a_s = 2'b01;
    end else if (fwd_hit(wb_valid_r, wb_rw_r, wb_rd_r, ex_rn)) begin
      fwd_a_s = 2'b10;
    end else begin
      fwd_a_s = 2'b00;
    end
    if (fwd_hit(mem_valid_r, mem_rw_r, mem_rd_r, ex_rm)) begin
      fwd_b_s = 2'b01;
    end else if (fwd_hit(wb_valid_r, wb_rw_r, wb_rd_r, ex_rm)) begin
      fwd_b_s = 2'b10;
    end else begin
      fwd_b_s = 2'b00;
    end
  end

  assign luh_s = id_valid & ex_valid_r & ex_ld_r & (ex_rd_r != ZERO_REG)
               & ((id_uses_rn & (id_rn == ex_rd_r)) | (id_uses_rm & (id_rm == ex_rd_r)));

  // State and stall-countdown registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_RUN;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next state and pipeline control; a taken branch preempts any stall
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    pc_write_s    = 1'b1;
    ifid_write_s  = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    flush_evt_s   = 1'b0;
    if (!reset_n) begin
      state_nxt_s = ST_RUN;
      cnt_nxt_s   = 2'd0;
    end else begin
      case (state_r)
        ST_RUN, ST_STALL: begin
          if (ex_br_taken) begin
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
            flush_evt_s   = 1'b1;
            state_nxt_s   = ST_FLUSH;
          end else if ((state_r == ST_STALL) || luh_s) begin
            pc_write_s    = 1'b0;
            ifid_write_s  = 1'b0;
            idex_bubble_s = 1'b1;
            if (state_r == ST_STALL) begin
              cnt_nxt_s   = cnt_r - 2'd1;
              state_nxt_s = (cnt_r <= 2'd1) ? ST_RUN : ST_STALL;
            end else begin
              cnt_nxt_s   = STALL_INIT;
              state_nxt_s = (STALL_INIT != 2'd0) ? ST_STALL : ST_RUN;
            end
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_FLUSH: state_nxt_s = ST_RUN;
        default:  state_nxt_s = ST_RUN;
      endcase
    end
  end

  assign pc_write    = pc_write_s;
  assign ifid_write  = ifid_write_s;
  assign ifid_flush  = ifid_flush_s;
  assign idex_bubble = idex_bubble_s;
  assign fwd_a       = fwd_a_s;
  assign fwd_b       = fwd_b_s;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_r, flush_cnt_r;

  // Stall-cycle and taken-branch flush event counters, free-running wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      stall_cnt_r <= stall_cnt_r + {31'd0, ~pc_write_s};
      flush_cnt_r <= flush_cnt_r + {31'd0, flush_evt_s};
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: one instance with 1 load-use bubble, one with 2.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       urn;
    logic       urm;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
  } id_t;

  typedef struct packed {
    logic       pcw;
    logic       ifw;
    logic       fl;
    logic       bub;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       pcw2;
  } exp_t;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid, id_uses_rn, id_uses_rm, id_reg_write, id_is_load, ex_br_taken;
  logic [4:0]  id_rn, id_rm, id_rd, ex_rn, ex_rm;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic        pc_write2, ifid_write2, ifid_flush2, idex_bubble2;
  logic [1:0]  fwd_a, fwd_b, fwd_a2, fwd_b2;
  logic [31:0] stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_rn(ex_rn), .ex_rm(ex_rm),
    .ex_br_taken(ex_br_taken), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.LOAD_USE_STALLS(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_rn(ex_rn), .ex_rm(ex_rm),
    .ex_br_taken(ex_br_taken), .pc_write(pc_write2), .ifid_write(ifid_write2),
    .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2), .fwd_a(fwd_a2), .fwd_b(fwd_b2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic id_t nop();
    return '0;
  endfunction

  function automatic id_t op(input logic [4:0] rd, input logic rw, input logic [4:0] rn,
                             input logic urn, input logic [4:0] rm, input logic urm);
    id_t r;
    r = '{v: 1'b1, rn: rn, rm: rm, urn: urn, urm: urm, rd: rd, rw: rw, ld: 1'b0};
    return r;
  endfunction

  function automatic id_t ldur(input logic [4:0] rd);
    id_t r;
    r = '{v: 1'b1, rn: 5'd0, rm: 5'd0, urn: 1'b1, urm: 1'b0, rd: rd, rw: 1'b1, ld: 1'b1};
    return r;
  endfunction

  function automatic exp_t e(input logic pcw, input logic ifw, input logic fl, input logic bub,
                             input logic [1:0] fa, input logic [1:0] fb, input logic pcw2);
    exp_t r;
    r = '{pcw: pcw, ifw: ifw, fl: fl, bub: bub, fa: fa, fb: fb, pcw2: pcw2};
    return r;
  endfunction

  // One cycle: drive after the rising edge, push the expectation, compare at the falling edge.
  task automatic step(input string name, input id_t id, input logic [4:0] ern,
                      input logic [4:0] erm, input logic br, input exp_t ex);
    exp_t x;
    @(posedge clk);
    #1;
    id_valid = id.v;  id_rn = id.rn;  id_rm = id.rm;  id_uses_rn = id.urn;
    id_uses_rm = id.urm;  id_rd = id.rd;  id_reg_write = id.rw;  id_is_load = id.ld;
    ex_rn = ern;  ex_rm = erm;  ex_br_taken = br;
    sb_q.push_back(ex);
    @(negedge clk);
    x = sb_q.pop_front();
    check({name, ".pc_write"},    {31'd0, pc_write},    {31'd0, x.pcw});
    check({name, ".ifid_write"},  {31'd0, ifid_write},  {31'd0, x.ifw});
    check({name, ".ifid_flush"},  {31'd0, ifid_flush},  {31'd0, x.fl});
    check({name, ".idex_bubble"}, {31'd0, idex_bubble}, {31'd0, x.bub});
    check({name, ".fwd_a"},       {30'd0, fwd_a},       {30'd0, x.fa});
    check({name, ".fwd_b"},       {30'd0, fwd_b},       {30'd0, x.fb});
    check({name, ".pc_write2"},   {31'd0, pc_write2},   {31'd0, x.pcw2});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t pass_e, stall_e, flush_e;
    id_t  held;
    logic [31:0] rv;
    pass_e  = e(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    stall_e = e(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
    flush_e = e(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1);

    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rv = $urandom;
      step("rst", id_t'(rv[19:0]), rv[24:20], rv[29:25], (i == 1) ? 1'b1 : rv[30], pass_e);
    end
    check("rst.stall_cnt", stall_cnt, 32'd0);
    check("rst.flush_cnt", flush_cnt, 32'd0);
    id_valid = 1'b0;  ex_br_taken = 1'b0;
    reset_n = 1'b1;

    // forwarding: ADDS X1 then SUBS X2,X1,X3; two apart; MEM and WB both X1; non-writing dest
    step("fwd1", op(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0), 5'd0, 5'd0, 1'b0, pass_e);
    step("fwd2", op(5'd2, 1'b1, 5'd1, 1'b1, 5'd3, 1'b1), 5'd0, 5'd0, 1'b0, pass_e);
    step("fwd_mem", nop(), 5'd1, 5'd3, 1'b0, e(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1));
    step("fwd_wb",  nop(), 5'd1, 5'd2, 1'b0, e(1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 2'b01, 1'b1));
    step("dbl1", op(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0), 5'd0, 5'd0, 1'b0, pass_e);
    step("dbl2", op(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0), 5'd5, 5'd5, 1'b0, pass_e);
    step("dbl3", nop(), 5'd0, 5'd0, 1'b0, pass_e);
    step("dbl_pri", nop(), 5'd1, 5'd1, 1'b0, e(1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1));
    step("nw1", op(5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0), 5'd0, 5'd0, 1'b0, pass_e);
    step("nw2", nop(), 5'd0, 5'd0, 1'b0, pass_e);
    step("nw_mem", nop(), 5'd7, 5'd7, 1'b0, pass_e);
    step("nw_wb",  nop(), 5'd7, 5'd7, 1'b0, pass_e);

    // load-use through rm: LDUR X4; ADD X5,X6,X4
    step("lu1", ldur(5'd4), 5'd0, 5'd0, 1'b0, pass_e);
    held = op(5'd5, 1'b1, 5'd6, 1'b1, 5'd4, 1'b1);
    step("lu_stall", held, 5'd10, 5'd0, 1'b0, stall_e);
    step("lu_held", held, 5'd0, 5'd0, 1'b0, e(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
    step("lu_fwd", nop(), 5'd6, 5'd4, 1'b0, e(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1));
    step("lu_done", nop(), 5'd0, 5'd0, 1'b0, pass_e);

    // load-use through rn; unused rm matching the load is not a hazard
    step("rn1", ldur(5'd8), 5'd0, 5'd0, 1'b0, pass_e);
    step("rn_nouse", op(5'd9, 1'b1, 5'd3, 1'b1, 5'd8, 1'b0), 5'd0, 5'd0, 1'b0, pass_e);
    step("rn2", ldur(5'd8), 5'd0, 5'd0, 1'b0, pass_e);
    held = op(5'd10, 1'b1, 5'd8, 1'b1, 5'd2, 1'b1);
    step("rn_stall", held, 5'd0, 5'd0, 1'b0, stall_e);
    step("rn_held", held, 5'd0, 5'd0, 1'b0, e(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
    step("rn_done", nop(), 5'd0, 5'd0, 1'b0, pass_e);

    // taken branch together with a load-use hazard: flush wins, FLUSH then RUN
    step("br1", ldur(5'd4), 5'd0, 5'd0, 1'b0, pass_e);
    step("br_luh", op(5'd6, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1), 5'd0, 5'd0, 1'b1, flush_e);
    step("br_flushst", nop(), 5'd0, 5'd0, 1'b0, pass_e);
    step("br2", nop(), 5'd0, 5'd0, 1'b1, flush_e);
    step("br2_flushst", nop(), 5'd0, 5'd0, 1'b0, pass_e);

    // third load-use, then reset while the 2-bubble instance is in STALL
    step("g1", ldur(5'd20), 5'd0, 5'd0, 1'b0, pass_e);
    held = op(5'd11, 1'b1, 5'd20, 1'b1, 5'd0, 1'b0);
    step("g_stall", held, 5'd0, 5'd0, 1'b0, stall_e);
    step("g_held", held, 5'd0, 5'd0, 1'b0, e(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0));
    check("cnt.stall1", stall_cnt,  PERF ? 32'd3 : 32'd0);
    check("cnt.flush1", flush_cnt,  PERF ? 32'd2 : 32'd0);
    check("cnt.stall2", stall_cnt2, PERF ? 32'd5 : 32'd0);
    check("cnt.flush2", flush_cnt2, PERF ? 32'd2 : 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst.pc_write2", {31'd0, pc_write2}, 32'd1);
    check("mid_rst.stall2", stall_cnt2, 32'd0);
    check("mid_rst.flush2", flush_cnt2, 32'd0);
    check("mid_rst.stall1", stall_cnt, 32'd0);
    step("mid_rst", held, 5'd0, 5'd0, 1'b1, pass_e);
    reset_n = 1'b1;
    step("post_rst", held, 5'd0, 5'd0, 1'b0, pass_e);

    // XZR is never forwarded nor a load-use source
    step("z1", op(5'd31, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0), 5'd0, 5'd0, 1'b0, pass_e);
    step("z2", nop(), 5'd0, 5'd0, 1'b0, pass_e);
    step("z_fwd", nop(), 5'd31, 5'd31, 1'b0, pass_e);
    step("z_ld", ldur(5'd31), 5'd31, 5'd31, 1'b0, pass_e);
    step("z_luh", op(5'd12, 1'b1, 5'd31, 1'b1, 5'd31, 1'b1), 5'd0, 5'd0, 1'b0, pass_e);

    check("sb.empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
